ex_mul_sequencer: RTL and testbench

Iterative multiply sequencer for the EX stage. When the ALU control code selects multiply (`3'b010`), this block takes over the operation from the single-cycle ALU. It runs a shift-add multiplier over several cycles and holds the pipeline with a stall until the product is ready. All other ALU codes pass through with no stall. It sits beside the ALU, and the EX result mux selects `result_o` whenever `result_valid_o` is high.

---
 rtl/ex_mul_sequencer.sv | 133 +++++++++++++
 tb/tb_ex_mul_sequencer.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_mul_sequencer.sv
// Iterative shift-add multiplier for the EX stage; stalls the pipeline until the product is ready.
// Optional macro MUL_EARLY_EXIT_EN: leave RUN as soon as the remaining multiplier bits are all zero.
module ex_mul_sequencer #(
  parameter int DATA_W = 32,
  parameter int STEP   = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              valid_i,
  input  logic              flush_i,
  input  logic [2:0]        ALUCtrl_i,
  input  logic [DATA_W-1:0] src1_i,
  input  logic [DATA_W-1:0] src2_i,
  output logic              stall_o,
  output logic              busy_o,
  output logic              result_valid_o,
  output logic [DATA_W-1:0] result_o
);

  localparam int          N       = DATA_W / STEP;
  localparam int          CNT_W   = $clog2(N) + 1;
  localparam logic [2:0]  ALU_MUL = 3'b010;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t              r_state;
  state_t              w_nextState;
  logic [DATA_W-1:0]   r_mcand;
  logic [DATA_W-1:0]   r_mplier;
  logic [DATA_W-1:0]   r_acc;
  logic [CNT_W-1:0]    r_cnt;

  logic                w_isMul;
  logic                w_lastStep;
  logic [DATA_W-1:0]   w_partial;
  logic [DATA_W-1:0]   w_mplierShifted;
  logic [DATA_W-1:0]   w_mcandShifted;

  // A mul seen while reset is asserted must not stall the pipeline.
  assign w_isMul = rst_i & start_i & valid_i & ~flush_i & (ALUCtrl_i == ALU_MUL);

  always_comb begin
    w_partial = '0;
    for (int j = 0; j < STEP; j++) begin
      if (r_mplier[j]) begin
        w_partial = w_partial + (r_mcand << j);
      end
    end
  end

  assign w_mplierShifted = r_mplier >> STEP;
  assign w_mcandShifted  = r_mcand << STEP;

`ifdef MUL_EARLY_EXIT_EN
  assign w_lastStep = (r_cnt == CNT_W'(N - 1)) || (w_mplierShifted == '0);
`else
  assign w_lastStep = (r_cnt == CNT_W'(N - 1));
`endif

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // DONE always returns to IDLE so the mul still sitting in EX is not taken twice.
  always_comb begin
    w_nextState = r_state;
    stall_o     = 1'b0;
    case (r_state)
      S_IDLE: begin
        stall_o = w_isMul;
        if (w_isMul) begin
          w_nextState = S_RUN;
        end
      end
      S_RUN: begin
        stall_o = ~flush_i;
        if (flush_i) begin
          w_nextState = S_IDLE;
        end else if (w_lastStep) begin
          w_nextState = S_DONE;
        end
      end
      S_DONE: begin
        w_nextState = S_IDLE;
      end
      default: begin
        w_nextState = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_isMul) begin
            r_mcand  <= src1_i;
            r_mplier <= src2_i;
            r_acc    <= '0;
            r_cnt    <= '0;
          end
        end
        S_RUN: begin
          r_acc    <= r_acc + w_partial;
          r_mcand  <= w_mcandShifted;
          r_mplier <= w_mplierShifted;
          r_cnt    <= r_cnt + CNT_W'(1);
        end
        default: begin
        end
      endcase
    end
  end

  assign busy_o         = (r_state != S_IDLE);
  assign result_valid_o = (r_state == S_DONE);
  assign result_o       = r_acc;

endmodule

// File: tb/tb_ex_mul_sequencer.sv
// Randomised self-checking bench for ex_mul_sequencer against a plain-arithmetic reference model.
// Honours MUL_EARLY_EXIT_EN when computing expected stall lengths.
module tb_ex_mul_sequencer;

  localparam int DATA_W = 32;
  localparam int STEP   = 1;
  localparam int N      = DATA_W / STEP;
  localparam int BUDGET = 200;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic              valid;
  logic              flush;
  logic [2:0]        aluCtrl;
  logic [DATA_W-1:0] src1;
  logic [DATA_W-1:0] src2;
  logic              stall;
  logic              busy;
  logic              resValid;
  logic [DATA_W-1:0] result;

  int nCompared;
  int nMismatched;

  ex_mul_sequencer #(.DATA_W(DATA_W), .STEP(STEP)) dut (
    .clk_i          (clk),
    .rst_i          (rst_n),
    .start_i        (start),
    .valid_i        (valid),
    .flush_i        (flush),
    .ALUCtrl_i      (aluCtrl),
    .src1_i         (src1),
    .src2_i         (src2),
    .stall_o        (stall),
    .busy_o         (busy),
    .result_valid_o (resValid),
    .result_o       (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: number of stalled cycles for a mul whose multiplier is b.
  function automatic int expStall(input logic [DATA_W-1:0] b);
    int bl;
    int steps;
    bl = 0;
    for (int i = 0; i < DATA_W; i++) begin
      if (b[i]) bl = i + 1;
    end
    steps = (bl + STEP - 1) / STEP;
    if (steps == 0) steps = 1;
`ifdef MUL_EARLY_EXIT_EN
    return 1 + steps;
`else
    return N + 1;
`endif
  endfunction

  function automatic logic [DATA_W-1:0] expProduct(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
    logic [2*DATA_W-1:0] full;
    full = {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};
    return full[DATA_W-1:0];
  endfunction

  task automatic driveIdle();
    valid   = 1'b0;
    flush   = 1'b0;
    aluCtrl = 3'b000;
  endtask

  task automatic driveMul(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
    start   = 1'b1;
    valid   = 1'b1;
    flush   = 1'b0;
    aluCtrl = 3'b010;
    src1    = a;
    src2    = b;
  endtask

  // Called just after a negedge with the mul already driven; returns in the DONE cycle at negedge+1.
  task automatic waitResult(output int stalls, output bit seen, output logic [DATA_W-1:0] res);
    stalls = 0;
    seen   = 1'b0;
    res    = '0;
    for (int c = 0; c < BUDGET; c++) begin
      #1;
      if (stall) stalls++;
      if (resValid) begin
        seen = 1'b1;
        res  = result;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic runMul(input string name, input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
    int stalls;
    bit seen;
    logic [DATA_W-1:0] res;
    driveMul(a, b);
    waitResult(stalls, seen, res);
    driveIdle();
    nCompared++;
    if (seen !== 1'b1) begin
      nMismatched++;
      $display("[TB] FAIL %s valid: got %0b expected 1", name, seen);
    end
    nCompared++;
    if (res !== expProduct(a, b)) begin
      nMismatched++;
      $display("[TB] FAIL %s result: got %h expected %h", name, res, expProduct(a, b));
    end
    nCompared++;
    if (stalls !== expStall(b)) begin
      nMismatched++;
      $display("[TB] FAIL %s stalls: got %0d expected %0d", name, stalls, expStall(b));
    end
    @(negedge clk);
    #1;
    nCompared++;
    if ({resValid, busy, stall} !== 3'b000) begin
      nMismatched++;
      $display("[TB] FAIL %s after: got valid/busy/stall %b expected 000", name, {resValid, busy, stall});
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    src1  = '0;
    src2  = '0;
    driveIdle();
    repeat (3) @(negedge clk);
    #1;
    nCompared++;
    if ({stall, busy, resValid, result} !== {3'b000, {DATA_W{1'b0}}}) begin
      nMismatched++;
      $display("[TB] FAIL reset_outputs: got %b %b %b %h expected 0 0 0 0", stall, busy, resValid, result);
    end
    @(negedge clk);
    rst_n = 1'b1;
    start = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_directed();
    runMul("mul_7x6", 32'd7, 32'd6);
    runMul("mul_ffxff", 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    runMul("mul_8000x2", 32'h8000_0000, 32'd2);
    runMul("mul_3x2", 32'd3, 32'd2);
    runMul("mul_9x0", 32'd9, 32'd0);
  endtask

  task automatic test_random();
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    for (int k = 0; k < 8; k++) begin
      a = $urandom;
      b = $urandom;
      if (k % 2 == 1) b = b >> $urandom_range(31, 1);
      runMul($sformatf("mul_rand%0d", k), a, b);
    end
  endtask

  task automatic test_passthrough();
    logic [2:0] codes [4] = '{3'b000, 3'b001, 3'b011, 3'b100};
    for (int k = 0; k < 6; k++) begin
      start = 1'b1;
      valid = 1'b1;
      flush = 1'b0;
      src1  = $urandom;
      src2  = $urandom;
      if (k < 4) begin
        aluCtrl = codes[k];
      end else begin
        aluCtrl = 3'b010;
        if (k == 4) start = 1'b0;
        else        valid = 1'b0;
      end
      for (int c = 0; c < 3; c++) begin
        #1;
        nCompared++;
        if ({stall, busy, resValid} !== 3'b000) begin
          nMismatched++;
          $display("[TB] FAIL pass_%0d: got stall/busy/valid %b expected 000", k, {stall, busy, resValid});
        end
        @(negedge clk);
      end
    end
    start = 1'b1;
    driveIdle();
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int s1;
    int s2;
    bit v1;
    bit v2;
    logic [DATA_W-1:0] r1;
    logic [DATA_W-1:0] r2;
    driveMul(32'd3, 32'd5);
    waitResult(s1, v1, r1);
    driveMul(32'd4, 32'd4);
    @(negedge clk);
    waitResult(s2, v2, r2);
    driveIdle();
    nCompared++;
    if ({v1, v2} !== 2'b11) begin
      nMismatched++;
      $display("[TB] FAIL b2b_valid: got %b expected 11", {v1, v2});
    end
    nCompared++;
    if (r1 !== 32'd15 || r2 !== 32'd16) begin
      nMismatched++;
      $display("[TB] FAIL b2b_results: got %0d,%0d expected 15,16", r1, r2);
    end
    nCompared++;
    if (s1 + s2 !== expStall(32'd5) + expStall(32'd4)) begin
      nMismatched++;
      $display("[TB] FAIL b2b_stalls: got %0d expected %0d", s1 + s2, expStall(32'd5) + expStall(32'd4));
    end
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_flush();
    bit sawValid;
    driveMul($urandom, 32'hFFFF_FFFF);
    repeat (10) @(negedge clk);
    flush = 1'b1;
    #1;
    nCompared++;
    if (stall !== 1'b0) begin
      nMismatched++;
      $display("[TB] FAIL flush_stall: got %b expected 0", stall);
    end
    @(negedge clk);
    driveIdle();
    #1;
    nCompared++;
    if ({busy, stall} !== 2'b00) begin
      nMismatched++;
      $display("[TB] FAIL flush_idle: got busy/stall %b expected 00", {busy, stall});
    end
    sawValid = 1'b0;
    for (int c = 0; c < N + 4; c++) begin
      @(negedge clk);
      #1;
      if (resValid) sawValid = 1'b1;
    end
    nCompared++;
    if (sawValid !== 1'b0) begin
      nMismatched++;
      $display("[TB] FAIL flush_novalid: got %b expected 0", sawValid);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_midrun();
    bit sawValid;
    driveMul(32'h1234_5678, 32'hFFFF_FFFF);
    repeat (5) @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    nCompared++;
    if ({stall, busy, resValid, result} !== {3'b000, {DATA_W{1'b0}}}) begin
      nMismatched++;
      $display("[TB] FAIL reset_midrun: got %b %b %b %h expected 0 0 0 0", stall, busy, resValid, result);
    end
    @(negedge clk);
    driveIdle();
    rst_n = 1'b1;
    sawValid = 1'b0;
    for (int c = 0; c < N + 4; c++) begin
      @(negedge clk);
      #1;
      if (resValid || busy) sawValid = 1'b1;
    end
    nCompared++;
    if (sawValid !== 1'b0) begin
      nMismatched++;
      $display("[TB] FAIL reset_noresult: got %b expected 0", sawValid);
    end
    @(negedge clk);
  endtask

  initial begin
    nCompared   = 0;
    nMismatched = 0;
    test_reset();
    test_directed();
    test_passthrough();
    test_random();
    test_back_to_back();
    test_flush();
    test_reset_midrun();
    runMul("mul_after_reset", 32'd11, 32'd13);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
